// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: instruction width, the NOP used for empty slots,
// and the per-entry record held in the fetch ring.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_ring.sv
// In-order ring of fetch entries: tail allocates on request, fill pointer
// tracks the oldest entry still waiting on memory, head feeds decode.
module fetch_ring
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_data,
    input  logic            deq,
    input  logic            flush,
    output fetch_entry_t    head
);

    localparam int unsigned PW = $clog2(DEPTH);
    typedef logic [PW-1:0] ptr_t;

    fetch_entry_t ent_q [DEPTH];
    fetch_entry_t ent_d [DEPTH];
    ptr_t         head_q, head_d;
    ptr_t         tail_q, tail_d;
    ptr_t         fill_q, fill_d;

    always_comb begin
        ent_d  = ent_q;
        head_d = head_q;
        tail_d = tail_q;
        fill_d = fill_q;
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_d[i].filled = 1'b0;
                ent_d[i].instr  = NOP_INSTR;
            end
            head_d = '0;
            tail_d = '0;
            fill_d = '0;
        end else begin
            if (deq) begin
                ent_d[head_q].filled = 1'b0;
                ent_d[head_q].instr  = NOP_INSTR;
                head_d = head_q + ptr_t'(1);
            end
            if (fill) begin
                ent_d[fill_q].instr  = fill_data;
                ent_d[fill_q].filled = 1'b1;
                fill_d = fill_q + ptr_t'(1);
            end
            // On a full ring tail == head: the new allocation must win over the dequeue clear.
            if (alloc) begin
                ent_d[tail_q] = '{pc: alloc_pc, instr: NOP_INSTR, filled: 1'b0};
                tail_d = tail_q + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '{pc: '0, instr: NOP_INSTR, filled: 1'b0};
            end
            head_q <= '0;
            tail_q <= '0;
            fill_q <= '0;
        end else begin
            ent_q  <= ent_d;
            head_q <= head_d;
            tail_q <= tail_d;
            fill_q <= fill_d;
        end
    end

    assign head = ent_q[head_q];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: one imem read per cycle at pc_if, in-order buffering toward
// decode, PC back-pressure, and dropping of wrong-path responses after a redirect.
module instr_fetch_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] pc_if,
    input  logic            j_br,
    output logic            fetch_stall,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    input  logic            id_ready
);
    import fetch_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);
    typedef logic [CW-1:0] cnt_t;

    cnt_t         count_q, count_d;
    cnt_t         discard_q, discard_d;
    cnt_t         unfilled_q, unfilled_d;
    logic [CW:0]  occupancy;
    logic         deq, slot_ok, req_fire, fill;
    fetch_entry_t head;

    fetch_ring #(.DEPTH(DEPTH)) u_ring (
        .clk       (clk),
        .reset_n   (reset_n),
        .alloc     (req_fire),
        .alloc_pc  (pc_if),
        .fill      (fill),
        .fill_data (imem_rsp_data),
        .deq       (deq),
        .flush     (j_br),
        .head      (head)
    );

    assign id_valid = head.filled;
    assign id_instr = head.instr;
    assign id_pc    = head.pc;

    // Stale reads still occupy memory slots, so they count against capacity.
    assign occupancy      = (CW+1)'(count_q) + (CW+1)'(discard_q);
    assign deq            = id_valid & id_ready & ~j_br;
    assign slot_ok        = (occupancy < (CW+1)'(DEPTH)) | deq;
    assign imem_req_valid = reset_n & ~j_br & slot_ok;
    assign imem_req_addr  = pc_if;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign fetch_stall    = ~req_fire;
    assign fill           = imem_rsp_valid & (discard_q == '0) & ~j_br;

    always_comb begin
        count_d    = count_q;
        discard_d  = discard_q;
        unfilled_d = unfilled_q;
        if (j_br) begin
            count_d    = '0;
            unfilled_d = '0;
            discard_d  = discard_q + unfilled_q - cnt_t'(imem_rsp_valid);
        end else begin
            count_d    = count_q + cnt_t'(req_fire) - cnt_t'(deq);
            unfilled_d = unfilled_q + cnt_t'(req_fire) - cnt_t'(fill);
            if (imem_rsp_valid && (discard_q != '0)) begin
                discard_d = discard_q - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q    <= '0;
            discard_q  <= '0;
            unfilled_q <= '0;
        end else begin
            count_q    <= count_d;
            discard_q  <= discard_d;
            unfilled_q <= unfilled_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue: bench-side PC and memory, queue-based
// reference of accepted fetches, and a negedge monitor that scores decode output.
module tb_instr_fetch_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [XLEN-1:0] pc_if;
    logic            j_br;
    logic            fetch_stall;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            id_valid;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic            id_ready;

    always #5 clk = ~clk;

    instr_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pc_if          (pc_if),
        .j_br           (j_br),
        .fetch_stall    (fetch_stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_ready       (id_ready)
    );

    // Scoreboard: accepted fetches on the live path, oldest first.
    typedef struct { logic [31:0] pc; bit filled; } sb_t;
    // Bench memory: in-flight reads in order, tagged stale once flushed.
    typedef struct { logic [31:0] pc; int unsigned due; bit stale; } mrq_t;

    sb_t         sb[$];
    mrq_t        mq[$];
    sb_t         mon_e;
    int unsigned cyc = 0;
    int unsigned last_due = 0;
    int          vectors = 0;
    int          errors  = 0;

    int unsigned lat_min = 1, lat_max = 1;
    int unsigned ready_pct = 100, idr_pct = 100, jbr_pct = 0, rst_permille = 0;
    bit          ready_toggle = 1'b0;
    bit          jbr_req = 1'b0;
    logic [31:0] jbr_target = 32'h100;
    int unsigned rst_cycles = 0;
    logic [31:0] bta = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        bit          ev, edeq, erv;
        int unsigned stale;
        ev    = (sb.size() > 0) && sb[0].filled;
        stale = 0;
        foreach (mq[i]) if (mq[i].stale) stale++;
        edeq  = ev && id_ready && !j_br;
        erv   = reset_n && !j_br && (((sb.size() + stale) < DEPTH) || edeq);
        check("id_valid", {31'b0, id_valid}, {31'b0, ev});
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, erv});
        check("fetch_stall", {31'b0, fetch_stall}, {31'b0, !(imem_req_valid && imem_req_ready)});
        check("req_addr", imem_req_addr, pc_if);
        if (!reset_n) check("stall_in_reset", {31'b0, fetch_stall}, 32'd1);
        if (edeq) begin
            mon_e = sb.pop_front();
            check("id_pc", id_pc, mon_e.pc);
            check("id_instr", id_instr, mem_word(mon_e.pc));
        end
    end

    task automatic step();
        logic        n_rst, n_jbr, n_rsp, n_rdy, n_idr;
        logic [31:0] n_pc, n_data;
        int unsigned due;
        @(negedge clk);
        #2;
        if (!reset_n) begin
            sb.delete();
            mq.delete();
            last_due = cyc;
        end else begin
            if (imem_rsp_valid) begin
                mrq_t r;
                r = mq.pop_front();
                if (!r.stale) begin
                    for (int i = 0; i < sb.size(); i++) begin
                        if (!sb[i].filled) begin
                            sb[i].filled = 1'b1;
                            break;
                        end
                    end
                end
            end
            if (j_br) begin
                sb.delete();
                foreach (mq[i]) mq[i].stale = 1'b1;
            end else if (imem_req_valid && imem_req_ready) begin
                sb.push_back('{pc: pc_if, filled: 1'b0});
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq.push_back('{pc: pc_if, due: due, stale: 1'b0});
            end
        end

        if (rst_cycles > 0) begin
            n_rst = 1'b0;
            rst_cycles--;
        end else begin
            n_rst = !($urandom_range(999, 0) < rst_permille);
        end
        if (!reset_n)         n_pc = '0;
        else if (j_br)        n_pc = bta;
        else if (!fetch_stall) n_pc = pc_if + 32'd4;
        else                  n_pc = pc_if;
        n_jbr = n_rst && (jbr_req || ($urandom_range(99, 0) < jbr_pct));
        if (jbr_req) bta = jbr_target;
        else         bta = $urandom & 32'h0000_0FFC;
        jbr_req = 1'b0;
        n_rsp  = n_rst && (mq.size() > 0) && (mq[0].due <= cyc + 1);
        n_data = n_rsp ? mem_word(mq[0].pc) : $urandom;
        n_rdy  = ready_toggle ? cyc[0] : ($urandom_range(99, 0) < ready_pct);
        n_idr  = $urandom_range(99, 0) < idr_pct;

        @(posedge clk);
        #1;
        reset_n        = n_rst;
        pc_if          = n_pc;
        j_br           = n_jbr;
        imem_rsp_valid = n_rsp;
        imem_rsp_data  = n_data;
        imem_req_ready = n_rdy;
        id_ready       = n_idr;
        cyc++;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    initial begin
        reset_n        = 1'b0;
        pc_if          = '0;
        j_br           = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        id_ready       = 1'b1;
        rst_cycles     = 2;

        // Back-to-back stream with single-cycle memory.
        run(24);
        // Decode stalls long enough to fill the ring, then releases.
        idr_pct = 0;
        run(6);
        idr_pct = 100;
        run(12);
        // Three-cycle memory, then a redirect to 0x100 with reads in flight.
        lat_min = 3; lat_max = 3;
        run(8);
        jbr_req = 1'b1; jbr_target = 32'h100;
        run(14);
        // Memory alternately refuses requests.
        lat_min = 1; lat_max = 1;
        ready_toggle = 1'b1;
        run(20);
        ready_toggle = 1'b0;
        // Reset while entries are queued.
        idr_pct = 0;
        run(5);
        rst_cycles = 1;
        run(4);
        idr_pct = 100;
        run(10);
        // Randomized mix of everything.
        lat_min = 1; lat_max = 4;
        ready_pct = 75; idr_pct = 70; jbr_pct = 6; rst_permille = 3;
        run(3000);
        // Quiet tail so the pipeline settles.
        jbr_pct = 0; rst_permille = 0; ready_pct = 100; idr_pct = 100;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
